// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of both requester handshakes and the RAM-side
// bus of the ram_arbiter.
//   Requester side (per port n = 0,1): reqn, wen, addrn, wdatan in;
//     ackn (one-cycle completion pulse) and rdatan (registered read data) out.
//   RAM side: ram_address, ram_data_in, ram_wren (active low) out;
//     ram_data_out in (asynchronous read data).
//   Status: busy (ACCESS or ACK), gnt_id (port being served).
// modport slave  : the arbiter's view.
// modport master : the requesters' + RAM's view (testbench / system).
interface ram_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_data_out;

    logic              busy;
    logic              gnt_id;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_data_out,
        output ack0, rdata0, ack1, rdata1,
        output ram_address, ram_data_in, ram_wren,
        output busy, gnt_id
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_data_out,
        input  ack0, rdata0, ack1, rdata1,
        input  ram_address, ram_data_in, ram_wren,
        input  busy, gnt_id
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter/sequencer in front of a single-port
// 32x1024 RAM (asynchronous read, synchronous write, active-low wren).
// Each access takes IDLE -> ACCESS -> ACK, one cycle each after IDLE,
// so one access completes every three cycles.
// Ports:
//   clock : rising-edge system clock
//   reset : synchronous, active-high
//   bus   : ram_arbiter_if.slave (requester handshakes, RAM bus, status)
// Build option:
//   RAM_ARB_RR_EN defined   -> round-robin tie break (grant port != last)
//   RAM_ARB_RR_EN undefined -> fixed priority, port 0 wins ties
module ram_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic          clock,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              gnt_id;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              win;

`ifdef RAM_ARB_RR_EN
    logic              last;
`endif

    // Winner among the currently requesting ports; only used in IDLE.
    always_comb begin
        win = 1'b0;
        if (bus.req0 && bus.req1) begin
`ifdef RAM_ARB_RR_EN
            win = ~last;
`else
            win = 1'b0;
`endif
        end else if (bus.req1) begin
            win = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            gnt_id    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gnt_id    <= win;
                        lat_addr  <= win ? bus.addr1  : bus.addr0;
                        lat_wdata <= win ? bus.wdata1 : bus.wdata0;
                        lat_we    <= win ? bus.we1    : bus.we0;
`ifdef RAM_ARB_RR_EN
                        last      <= win;
`endif
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The write commits in the RAM on this same edge.
                    if (!lat_we) begin
                        if (gnt_id) rdata1 <= bus.ram_data_out;
                        else        rdata0 <= bus.ram_data_out;
                    end
                    if (gnt_id) ack1 <= 1'b1;
                    else        ack0 <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM bus is only driven during ACCESS. reset gates wren directly so a
    // write caught by reset in its ACCESS cycle never lands in the RAM.
    assign bus.ram_address = (state == ACCESS) ? lat_addr  : '0;
    assign bus.ram_data_in = (state == ACCESS) ? lat_wdata : '0;
    assign bus.ram_wren    = ~((state == ACCESS) && lat_we && !reset);

    assign bus.ack0   = ack0;
    assign bus.ack1   = ack1;
    assign bus.rdata0 = rdata0;
    assign bus.rdata1 = rdata1;
    assign bus.busy   = (state != IDLE);
    assign bus.gnt_id = gnt_id;
endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: async read, sync active-low write, known initial contents.
    logic [31:0] mem     [0:1023];
    bit          written [0:1023];

    function automatic logic [31:0] init_val(input logic [9:0] a);
        return 32'h5A000000 | {22'd0, a};
    endfunction

    assign bus.ram_data_out = written[bus.ram_address] ? mem[bus.ram_address]
                                                       : init_val(bus.ram_address);
    always @(posedge clock) begin
        if (!bus.ram_wren) begin
            mem[bus.ram_address]     <= bus.ram_data_in;
            written[bus.ram_address] <= 1'b1;
        end
    end

    // Reference model: transaction-level memory, expected read-data registers
    // and the port granted most recently.
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_r [2];
    int          last_g;

    int vectors;
    int miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int tie_winner();
`ifdef RAM_ARB_RR_EN
        return (last_g == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Issue a request on each active port at once, then follow the
    // handshake cycle by cycle against the model's schedule.
    task automatic run_txn(input bit a0, input bit w0, input logic [9:0] ad0, input logic [31:0] d0,
                           input bit a1, input bit w1, input logic [9:0] ad1, input logic [31:0] d1);
        bit          act [2];
        bit          we  [2];
        logic [9:0]  ad  [2];
        logic [31:0] d   [2];
        int          acc_k [2];
        int          ack_k [2];
        int          order [2];
        int          n;
        act[0] = a0; we[0] = w0; ad[0] = ad0; d[0] = d0;
        act[1] = a1; we[1] = w1; ad[1] = ad1; d[1] = d1;
        acc_k[0] = -1; acc_k[1] = -1; ack_k[0] = -1; ack_k[1] = -1;
        if (a0 && a1) begin
            order[0] = tie_winner();
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = a0 ? 0 : 1;
            order[1] = 0;
            n = 1;
        end
        for (int i = 0; i < n; i++) begin
            int p;
            p = order[i];
            acc_k[p] = 1 + 3 * i;
            ack_k[p] = 2 + 3 * i;
            last_g = p;
            if (we[p]) ref_mem[ad[p]] = d[p];
            else       exp_r[p] = ref_mem[ad[p]];
        end

        bus.req0 = a0; bus.we0 = w0; bus.addr0 = ad0; bus.wdata0 = d0;
        bus.req1 = a1; bus.we1 = w1; bus.addr1 = ad1; bus.wdata1 = d1;

        for (int k = 1; k <= 7; k++) begin
            bit in_acc;
            int accp;
            @(negedge clock);
            in_acc = (k == acc_k[0]) || (k == acc_k[1]);
            accp   = (k == acc_k[1]) ? 1 : 0;
            chk("ack0", 32'(bus.ack0), 32'(k == ack_k[0]));
            chk("ack1", 32'(bus.ack1), 32'(k == ack_k[1]));
            chk("ram_wren", 32'(bus.ram_wren), 32'(!(in_acc && we[accp])));
            chk("busy", 32'(bus.busy), 32'(in_acc || k == ack_k[0] || k == ack_k[1]));
            if (in_acc) begin
                chk("ram_address", 32'(bus.ram_address), 32'(ad[accp]));
                chk("gnt_id", 32'(bus.gnt_id), 32'(accp));
                if (we[accp]) chk("ram_data_in", bus.ram_data_in, d[accp]);
            end
            if (k == ack_k[0]) begin
                chk("rdata0", bus.rdata0, exp_r[0]);
                bus.req0 = 1'b0;
            end
            if (k == ack_k[1]) begin
                chk("rdata1", bus.rdata1, exp_r[1]);
                bus.req1 = 1'b0;
            end
        end
    endtask

    typedef struct {
        bit          a0;
        bit          w0;
        logic [9:0]  ad0;
        logic [31:0] d0;
        bit          a1;
        bit          w1;
        logic [9:0]  ad1;
        logic [31:0] d1;
        logic [31:0] r0;
        logic [31:0] r1;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int acks_seen;
        int got_g [4];
        int exp_g [4];

        vectors     = 0;
        miscompares = 0;
        last_g      = 1;
        exp_r[0]    = '0;
        exp_r[1]    = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(10'(i));

        //         a0 w0 ad0     d0            a1 w1 ad1     d1            r0            r1
        tbl[0] = '{1, 1, 10'h005, 32'hDEADBEEF, 0, 0, 10'h000, 32'h0,        32'h0,        32'h0};
        tbl[1] = '{1, 0, 10'h005, 32'h0,        0, 0, 10'h000, 32'h0,        32'hDEADBEEF, 32'h0};
        tbl[2] = '{1, 1, 10'h3FF, 32'h12345678, 0, 0, 10'h000, 32'h0,        32'hDEADBEEF, 32'h0};
        tbl[3] = '{0, 0, 10'h000, 32'h0,        1, 0, 10'h3FF, 32'h0,        32'hDEADBEEF, 32'h12345678};
        tbl[4] = '{1, 0, 10'h005, 32'h0,        1, 0, 10'h005, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        tbl[5] = '{1, 1, 10'h020, 32'h11112222, 1, 0, 10'h020, 32'h0,        32'hDEADBEEF, 32'h11112222};
        tbl[6] = '{1, 0, 10'h021, 32'h0,        1, 1, 10'h021, 32'h33334444, 32'h5A000021, 32'h11112222};
        tbl[7] = '{0, 0, 10'h000, 32'h0,        1, 0, 10'h021, 32'h0,        32'h5A000021, 32'h33334444};

        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("reset ack0", 32'(bus.ack0), 32'd0);
        chk("reset ack1", 32'(bus.ack1), 32'd0);
        chk("reset ram_wren", 32'(bus.ram_wren), 32'd1);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset rdata0", bus.rdata0, 32'd0);
        chk("reset rdata1", bus.rdata1, 32'd0);
        chk("reset gnt_id", 32'(bus.gnt_id), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].a0, tbl[i].w0, tbl[i].ad0, tbl[i].d0,
                    tbl[i].a1, tbl[i].w1, tbl[i].ad1, tbl[i].d1);
            chk($sformatf("tbl%0d rdata0", i), bus.rdata0, tbl[i].r0);
            chk($sformatf("tbl%0d rdata1", i), bus.rdata1, tbl[i].r1);
        end

        // addr0 changes during ACCESS: the latched address must be used.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'h005;
        @(negedge clock);
        chk("latched addr", 32'(bus.ram_address), 32'h005);
        bus.addr0 = 10'h3FF;
        #1;
        chk("latched addr after change", 32'(bus.ram_address), 32'h005);
        @(negedge clock);
        chk("addr-change ack0", 32'(bus.ack0), 32'd1);
        chk("addr-change rdata0", bus.rdata0, 32'hDEADBEEF);
        bus.req0 = 1'b0;
        last_g   = 0;
        exp_r[0] = ref_mem[10'h005];
        @(negedge clock);

        // Both ports request reads continuously: record the first four grants.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'h005;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            exp_g[i] = tie_winner();
            last_g   = exp_g[i];
            got_g[i] = -1;
        end
        exp_r[0] = ref_mem[10'h005];
        exp_r[1] = ref_mem[10'h3FF];
        acks_seen = 0;
        for (int k = 0; k < 14 && acks_seen < 4; k++) begin
            @(negedge clock);
            chk("single ack", 32'(bus.ack0 && bus.ack1), 32'd0);
            if (bus.ack0 || bus.ack1) begin
                got_g[acks_seen] = bus.ack1 ? 1 : 0;
                if (bus.ack0) chk("stream rdata0", bus.rdata0, exp_r[0]);
                else          chk("stream rdata1", bus.rdata1, exp_r[1]);
                acks_seen++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int i = 0; i < 4; i++) chk($sformatf("grant %0d", i), 32'(got_g[i]), 32'(exp_g[i]));
        @(negedge clock);
        chk("stream idle busy", 32'(bus.busy), 32'd0);

        // Reset during the ACCESS cycle of a write: aborted, no ack, no commit.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 10'h010; bus.wdata0 = 32'hCAFEF00D;
        @(negedge clock);
        chk("abort wren before reset", 32'(bus.ram_wren), 32'd0);
        reset = 1'b1;
        #1;
        chk("abort wren forced", 32'(bus.ram_wren), 32'd1);
        @(negedge clock);
        reset    = 1'b0;
        bus.req0 = 1'b0;
        last_g   = 1;
        exp_r[0] = '0;
        exp_r[1] = '0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort rdata0", bus.rdata0, 32'd0);
        chk("abort rdata1", bus.rdata1, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("abort ack0", 32'(bus.ack0), 32'd0);
            @(negedge clock);
        end
        run_txn(1, 0, 10'h010, 32'h0, 0, 0, 10'h000, 32'h0);
        chk("abort prior contents", bus.rdata0, 32'h5A000010);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            bit a0, a1;
            a0 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom_range(0, 1));
            if (!a0 && !a1) a0 = 1'b1;
            run_txn(a0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), $urandom,
                    a1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
